// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: row-scans a 4x3 matrix keypad, debounces press and
// release, and hands one key event at a time to the consumer via valid/ack.
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   scan_enable          1 = scan keypad, 0 = idle and discard any pending event
//   col1..col3           synchronised active-high column levels
//   row1..row4           row drives, one-hot while scanning, all zero when idle
//   key_valid/key_code   event handshake; code 0-9, 4'hA = star, 4'hB = sharp
//   key_ack              consumer accepts the event in any cycle key_valid=1
//   key_pressed          1 while the accepted key is still physically held
module keypad_scan_controller #(
   parameter int unsigned SCAN_CYCLES     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned CNT_W           = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       scan_enable,
   input  logic       col1,
   input  logic       col2,
   input  logic       col3,
   output logic       row1,
   output logic       row2,
   output logic       row3,
   output logic       row4,
   output logic       key_valid,
   output logic [3:0] key_code,
   input  logic       key_ack,
   output logic       key_pressed
);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_DONE  = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, PRESSED} state_t;

   state_t           state, state_n;
   logic [1:0]       row_idx, row_idx_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       col_lat, col_lat_n;
   logic [3:0]       rows_q, rows_n;
   logic             key_valid_n, key_pressed_n;
   logic [3:0]       key_code_n;
   logic [2:0]       cols;
   logic             one_col;
   logic             released;

   assign cols    = {col3, col2, col1};
   // More than one column high is treated as ghosting and skipped.
   assign one_col = (cols == 3'b001) || (cols == 3'b010) || (cols == 3'b100);

   assign row1 = rows_q[0];
   assign row2 = rows_q[1];
   assign row3 = rows_q[2];
   assign row4 = rows_q[3];

   // Row index (0 = row1) and one-hot column pattern to key code.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [2:0] c);
      case ({r, c})
         5'b00_001: key_map = 4'd1;
         5'b00_010: key_map = 4'd2;
         5'b00_100: key_map = 4'd3;
         5'b01_001: key_map = 4'd4;
         5'b01_010: key_map = 4'd5;
         5'b01_100: key_map = 4'd6;
         5'b10_001: key_map = 4'd7;
         5'b10_010: key_map = 4'd8;
         5'b10_100: key_map = 4'd9;
         5'b11_001: key_map = 4'hA;
         5'b11_010: key_map = 4'd0;
         5'b11_100: key_map = 4'hB;
         default:   key_map = 4'd0;
      endcase
   endfunction

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         row_idx     <= 2'd0;
         cnt         <= '0;
         col_lat     <= 3'b000;
         rows_q      <= 4'b0000;
         key_valid   <= 1'b0;
         key_code    <= 4'd0;
         key_pressed <= 1'b0;
      end else begin
         state       <= state_n;
         row_idx     <= row_idx_n;
         cnt         <= cnt_n;
         col_lat     <= col_lat_n;
         rows_q      <= rows_n;
         key_valid   <= key_valid_n;
         key_code    <= key_code_n;
         key_pressed <= key_pressed_n;
      end
   end

   // Next-state and next-output logic; cnt is the scan, match and release counter.
   always_comb begin
      state_n       = state;
      row_idx_n     = row_idx;
      cnt_n         = cnt;
      col_lat_n     = col_lat;
      key_valid_n   = key_valid;
      key_code_n    = key_code;
      key_pressed_n = key_pressed;
      released      = 1'b0;

      case (state)
         IDLE: begin
            if (scan_enable) begin
               state_n   = SCAN;
               row_idx_n = 2'd0;
               cnt_n     = '0;
            end
         end
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_n = '0;
               if (one_col) begin
                  col_lat_n = cols;
                  if (DEBOUNCE_CYCLES == 1) begin
                     state_n       = PRESSED;
                     key_valid_n   = 1'b1;
                     key_code_n    = key_map(row_idx, cols);
                     key_pressed_n = 1'b1;
                  end else begin
                     // The scan sample itself is the first match.
                     state_n = DEBOUNCE;
                     cnt_n   = CNT_W'(1);
                  end
               end else begin
                  row_idx_n = row_idx + 2'd1;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (cols != col_lat) begin
               state_n   = SCAN;
               row_idx_n = row_idx + 2'd1;
               cnt_n     = '0;
            end else if (cnt == DEB_LAST) begin
               state_n       = PRESSED;
               key_valid_n   = 1'b1;
               key_code_n    = key_map(row_idx, col_lat);
               key_pressed_n = 1'b1;
               cnt_n         = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            // Once the release is debounced it stays latched until exit.
            released = !key_pressed;
            if (key_pressed) begin
               if (cols != 3'b000) begin
                  cnt_n = '0;
               end else if (cnt == DEB_LAST) begin
                  key_pressed_n = 1'b0;
                  released      = 1'b1;
                  cnt_n         = DEB_DONE;
               end else begin
                  cnt_n = cnt + CNT_W'(1);
               end
            end
            if (key_valid && key_ack) begin
               key_valid_n = 1'b0;
            end
            if (released && !key_valid_n) begin
               state_n   = SCAN;
               row_idx_n = 2'd0;
               cnt_n     = '0;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // Disabling scanning discards everything, including a pending event.
      if (!scan_enable) begin
         state_n       = IDLE;
         row_idx_n     = 2'd0;
         cnt_n         = '0;
         col_lat_n     = 3'b000;
         key_valid_n   = 1'b0;
         key_code_n    = 4'd0;
         key_pressed_n = 1'b0;
      end

      rows_n = (state_n == IDLE) ? 4'b0000 : 4'(4'b0001 << row_idx_n);
   end

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: directed bench with a keypad matrix model and an
// event scoreboard; expected key codes are queued by the stimulus and checked
// by a monitor whenever key_valid rises.
module tb_keypad_scan_controller;

   logic       clk;
   logic       reset_n;
   logic       scan_enable;
   logic       col1, col2, col3;
   logic       row1, row2, row3, row4;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ack;
   logic       key_pressed;

   int         press_r;   // 0 = no key, 1..4 = row of held key
   int         press_c;   // 1..3 = column of held key
   logic       bounce;    // forces the held key's contact open
   logic       hit;

   int         checks;
   int         errors;
   int         cyc;

   logic [3:0] exp_q[$];
   logic       prev_valid;
   logic [3:0] prev_code;

   keypad_scan_controller #(
      .SCAN_CYCLES     (4),
      .DEBOUNCE_CYCLES (8),
      .CNT_W           (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .scan_enable (scan_enable),
      .col1        (col1),
      .col2        (col2),
      .col3        (col3),
      .row1        (row1),
      .row2        (row2),
      .row3        (row3),
      .row4        (row4),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .key_ack     (key_ack),
      .key_pressed (key_pressed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Keypad matrix: a held key connects its row drive to its column.
   assign hit  = !bounce && ((press_r == 1 && row1) || (press_r == 2 && row2) ||
                             (press_r == 3 && row3) || (press_r == 4 && row4));
   assign col1 = hit && (press_c == 1);
   assign col2 = hit && (press_c == 2);
   assign col3 = hit && (press_c == 3);

   function automatic logic [3:0] rows_v();
      return {row1, row2, row3, row4};
   endfunction

   function automatic logic [3:0] row_exp(input int idx);
      logic [3:0] base;
      base = 4'b1000;
      return 4'(base >> idx);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic go_to(input int target);
      while (cyc < target) step();
   endtask

   // Pass through IDLE so that cycle 0 is the first cycle row1 is driven.
   task automatic restart();
      scan_enable = 1'b0;
      step();
      scan_enable = 1'b1;
      step();
      cyc = 0;
   endtask

   task automatic press_ack(input int r, input int c, input logic [3:0] code, input int lat);
      int n;
      exp_q.push_back(code);
      press_r = r;
      press_c = c;
      n = 0;
      while (!key_valid && n < 200) begin
         step();
         n++;
      end
      chk("valid_seen", 32'(key_valid), 32'd1);
      if (lat >= 0) chk("valid_latency", 32'(cyc), 32'(lat));
      chk("pressed_with_valid", 32'(key_pressed), 32'd1);
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      chk("valid_drop_after_ack", 32'(key_valid), 32'd0);
      press_r = 0;
      n = 0;
      while (key_pressed && n < 50) begin
         step();
         n++;
      end
      chk("release_seen", 32'(key_pressed), 32'd0);
      chk("rescan_row1", 32'(rows_v()), 32'h8);
   endtask

   // Scoreboard monitor: one expected code per rising edge of key_valid.
   initial begin
      prev_valid = 1'b0;
      prev_code  = 4'd0;
      forever begin
         @(negedge clk);
         if (key_valid && !prev_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: got code %0h expected no event", key_code);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (key_code !== e) begin
                  errors++;
                  $display("FAIL event_code: got %0h expected %0h", key_code, e);
               end
            end
         end else if (key_valid && prev_valid) begin
            checks++;
            if (key_code !== prev_code) begin
               errors++;
               $display("FAIL code_stable: got %0h expected %0h", key_code, prev_code);
            end
         end
         prev_valid = key_valid;
         prev_code  = key_code;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      reset_n     = 1'b0;
      scan_enable = 1'b0;
      key_ack     = 1'b0;
      press_r     = 0;
      press_c     = 0;
      bounce      = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_rows", 32'(rows_v()), 32'h0);
      chk("reset_valid", 32'(key_valid), 32'd0);
      chk("reset_code", 32'(key_code), 32'd0);
      chk("reset_pressed", 32'(key_pressed), 32'd0);
      reset_n = 1'b1;
      step();
      chk("idle_rows", 32'(rows_v()), 32'h0);

      // 1: idle scan, 4 cycles per row, wrap to row1 at cycle 16.
      scan_enable = 1'b1;
      step();
      cyc = 0;
      for (int k = 0; k <= 16; k++) begin
         chk("scan_rows", 32'(rows_v()), 32'(row_exp((k / 4) % 4)));
         chk("scan_no_valid", 32'(key_valid), 32'd0);
         step();
      end

      // 2: hold '5', valid at 15, ack at 17, release at 30, key_pressed drops at 38.
      press_r = 2;
      press_c = 2;
      exp_q.push_back(4'd5);
      restart();
      go_to(14);
      chk("k5_valid_c14", 32'(key_valid), 32'd0);
      go_to(15);
      chk("k5_valid_c15", 32'(key_valid), 32'd1);
      chk("k5_code", 32'(key_code), 32'd5);
      chk("k5_pressed", 32'(key_pressed), 32'd1);
      go_to(17);
      key_ack = 1'b1;
      chk("k5_valid_c17", 32'(key_valid), 32'd1);
      step();
      key_ack = 1'b0;
      chk("k5_valid_c18", 32'(key_valid), 32'd0);
      chk("k5_rows_held", 32'(rows_v()), 32'h4);
      go_to(30);
      press_r = 0;
      go_to(37);
      chk("k5_pressed_c37", 32'(key_pressed), 32'd1);
      go_to(38);
      chk("k5_pressed_c38", 32'(key_pressed), 32'd0);
      chk("k5_rescan_row1", 32'(rows_v()), 32'h8);

      // 3: col2 bounces at cycle 10 during row2 debounce.
      press_r = 2;
      press_c = 2;
      restart();
      go_to(10);
      bounce = 1'b1;
      go_to(11);
      bounce  = 1'b0;
      press_r = 0;
      chk("bounce_row3", 32'(rows_v()), 32'h2);
      while (cyc < 45) begin
         chk("bounce_no_valid", 32'(key_valid), 32'd0);
         step();
      end

      // 4: sharp then star.
      restart();
      press_ack(4, 3, 4'hB, 23);
      press_ack(4, 1, 4'hA, -1);

      // 5: hold '1' without ack; release at 20, ack at 100.
      press_r = 1;
      press_c = 1;
      exp_q.push_back(4'd1);
      restart();
      go_to(11);
      chk("k1_code", 32'(key_code), 32'd1);
      while (cyc < 100) begin
         if (cyc == 20) press_r = 0;
         if (cyc == 27) chk("k1_pressed_c27", 32'(key_pressed), 32'd1);
         if (cyc == 28) chk("k1_pressed_c28", 32'(key_pressed), 32'd0);
         chk("k1_valid_held", 32'(key_valid), 32'd1);
         step();
      end
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      chk("k1_valid_c101", 32'(key_valid), 32'd0);
      go_to(104);
      chk("k1_rows_c104", 32'(rows_v()), 32'h8);
      go_to(105);
      chk("k1_rows_c105", 32'(rows_v()), 32'h4);

      // 6a: drop scan_enable while key_valid=1.
      press_r = 2;
      press_c = 2;
      exp_q.push_back(4'd5);
      restart();
      go_to(15);
      chk("dis_valid_before", 32'(key_valid), 32'd1);
      scan_enable = 1'b0;
      step();
      chk("dis_valid", 32'(key_valid), 32'd0);
      chk("dis_pressed", 32'(key_pressed), 32'd0);
      chk("dis_code", 32'(key_code), 32'd0);
      chk("dis_rows", 32'(rows_v()), 32'h0);
      press_r = 0;
      scan_enable = 1'b1;
      step();
      chk("reen_rows", 32'(rows_v()), 32'h8);

      // 6b: reset pulse mid-debounce.
      press_r = 2;
      press_c = 2;
      restart();
      go_to(10);
      chk("rst_rows_before", 32'(rows_v()), 32'h4);
      reset_n = 1'b0;
      #1;
      chk("rst_rows", 32'(rows_v()), 32'h0);
      chk("rst_valid", 32'(key_valid), 32'd0);
      chk("rst_pressed", 32'(key_pressed), 32'd0);
      press_r = 0;
      step();
      reset_n = 1'b1;
      step();
      chk("rst_rescan_row1", 32'(rows_v()), 32'h8);
      repeat (40) step();

      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/keypad_scan_controller.md
Name: keypad_scan_controller

Overview:
Sequences the 4x3 matrix keypad that feeds the safe's key encoder, comparator and state manager. It drives one row at a time and samples the three columns. It debounces presses and releases, and hands one key event at a time to the safe logic through a valid/ack handshake. Star and sharp are reported as distinct codes, so downstream logic never has to decode raw row/column levels.

Parameters:
SCAN_CYCLES, 4, clock cycles each row is driven before its columns are sampled (>=2)
DEBOUNCE_CYCLES, 8, consecutive identical samples required to accept a press or a release (>=1)
CNT_W, 4, width of the shared scan/debounce counter; must hold max(SCAN_CYCLES, DEBOUNCE_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
scan_enable  input  1  level; 1 = scanning allowed, 0 = keypad idle
col1, col2, col3  input  1 each  raw column levels, active-high, already synchronised
row1, row2, row3, row4  output  1 each  row drives, one-hot or all zero
key_valid  output  1  key event available; held until accepted
key_code  output  4  0-9 for digit keys, 4'hA = star, 4'hB = sharp
key_ack  input  1  consumer accepts the event in any cycle key_valid=1
key_pressed  output  1  1 while an accepted key is still physically held

Behaviour:
- Reset (async): state IDLE, rows 0000, key_valid 0, key_code 0, key_pressed 0, counter 0, row index 0.
- States: IDLE, SCAN, DEBOUNCE, PRESSED.
- IDLE:
  - Rows 0.
  - scan_enable=1 -> SCAN with row1 and counter 0 on the next cycle.
- SCAN:
  - Drive the current row one-hot. The counter increments each cycle.
  - At counter==SCAN_CYCLES-1, sample columns:
    - Exactly one column high: latch row/col, go to DEBOUNCE with the match count = 1, keep the same row.
    - Zero or more than one column high (ghosting): advance the row 1->2->3->4->1 and clear the counter.
- DEBOUNCE:
  - Same row driven. Sample columns each cycle.
  - Sample equals latched pattern: increment match count.
  - Any mismatch: back to SCAN on the next row, nothing reported.
  - Match count reaches DEBOUNCE_CYCLES: next cycle key_valid=1, key_code set, key_pressed=1, state PRESSED.
- key_code map:
  - row1: col1/2/3 = 1/2/3
  - row2: col1/2/3 = 4/5/6
  - row3: col1/2/3 = 7/8/9
  - row4: col1=A, col2=0, col3=B
- PRESSED:
  - Row held.
  - key_valid and key_code stay stable until a cycle with key_ack=1; key_valid falls the next cycle.
  - Release counter: clears whenever any column is high; increments while all columns are 0.
  - Counter reaches DEBOUNCE_CYCLES: key_pressed drops.
  - Exit to SCAN at row1 only when both are true: release debounced and event acked (either order).
  - No new event is ever generated while key_valid=1, so there is no overwrite.
- key_ack while key_valid=0: ignored.
- key_ack in the same cycle key_valid rises: accepted in that cycle.
- scan_enable=0 in any state: next cycle go to IDLE, rows 0, key_valid 0, key_pressed 0, counters cleared, pending event discarded.
- reset_n low mid-operation: immediate return to reset values, including a pending key_valid.
- Counter and row index wrap only as described. The counter never exceeds its terminal value.

Test Plan:
Parameters for all scenarios: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8; scan_enable=1 from cycle 0, reset_n released before cycle 0.
1. Idle scan, no keys -> rows cycle 1000, 0100, 0010, 0001, 4 cycles each, wrap to row1 at cycle 16; key_valid stays 0.
2. Hold '5' (row2/col2) from cycle 0, ack 2 cycles after valid -> sample at cycle 7, key_valid=1 at cycle 15 with key_code=5, drops the cycle after ack; release at cycle 30 -> key_pressed=0 at cycle 38, SCAN restarts at row1.
3. col2 bounces low at cycle 10 during row2 debounce -> no key_valid; scan resumes on row3 at cycle 11.
4. row4/col3 then row4/col1 with ack -> codes B then A, each exactly one valid period; sharp and star never produce a digit code.
5. Hold '1' with no ack for 100 cycles while releasing at cycle 20 -> key_valid and code 1 stay stable, no second event; ack at cycle 100 -> SCAN next cycle.
6. Drop scan_enable with key_valid=1, and separately pulse reset_n low mid-DEBOUNCE -> outputs return to 0 immediately (reset) or next cycle (enable); scanning restarts at row1 on re-enable.
